// File: rtl/bp_fe_pc_gen_ftq_if.sv
// Fetch-side valid/yumi channel between the fetch-target queue and the I$.
interface bp_fe_pc_gen_ftq_if
  #(parameter int unsigned vaddr_width_p = 39
   ,parameter int unsigned ftq_els_p     = 8
   );

   localparam int unsigned ftq_ptr_width_lp = $clog2(ftq_els_p);

   logic                        fetch_v_o;
   logic [vaddr_width_p-1:0]    fetch_pc_o;
   logic                        fetch_taken_o;
   logic [ftq_ptr_width_lp-1:0] fetch_idx_o;
   logic                        fetch_yumi_i;

   modport master (output fetch_v_o, fetch_pc_o, fetch_taken_o, fetch_idx_o,
                   input  fetch_yumi_i);
   modport slave  (input  fetch_v_o, fetch_pc_o, fetch_taken_o, fetch_idx_o,
                   output fetch_yumi_i);

endinterface

// File: rtl/bp_fe_pc_gen_ftq.sv
// Decoupled next-PC generator that runs ahead of the I$ and fills a fetch-target
// queue drained by valid/yumi, retired by commit, flushed by redirect or override.
module bp_fe_pc_gen_ftq
  #(parameter int unsigned vaddr_width_p = 39
   ,parameter int unsigned fetch_bytes_p = 8
   ,parameter int unsigned ftq_els_p     = 8
   ,parameter logic [vaddr_width_p-1:0] boot_pc_p = 39'h0080000000
   ,localparam int unsigned ftq_ptr_width_lp = $clog2(ftq_els_p)
   )
  (input  logic                        clk_i
  ,input  logic                        reset_n_i
  ,input  logic                        init_done_i
  ,output logic [vaddr_width_p-1:0]    gen_pc_o
  ,input  logic                        pred_taken_i
  ,input  logic [vaddr_width_p-1:0]    pred_tgt_i
  ,input  logic                        redirect_v_i
  ,input  logic [vaddr_width_p-1:0]    redirect_pc_i
  ,input  logic                        ovr_v_i
  ,input  logic [ftq_ptr_width_lp-1:0] ovr_idx_i
  ,input  logic [vaddr_width_p-1:0]    ovr_pc_i
  ,bp_fe_pc_gen_ftq_if.master          fetch_if
  ,input  logic                        commit_v_i
  ,output logic [ftq_ptr_width_lp:0]   count_o
  ,output logic                        full_o
  ,output logic                        empty_o
  );

   typedef enum logic {e_init, e_run} state_e;
   typedef logic [ftq_ptr_width_lp:0] ptr_t;

   localparam logic [vaddr_width_p-1:0] blk_mask_lp  = vaddr_width_p'(fetch_bytes_p - 1);
   localparam logic [vaddr_width_p-1:0] blk_bytes_lp = vaddr_width_p'(fetch_bytes_p);
   localparam int unsigned              wrap_lp      = ftq_ptr_width_lp;

   state_e                      state_q, state_d;
   logic [vaddr_width_p-1:0]    gen_pc_q, gen_pc_d;
   ptr_t                        head_q, head_d, fetch_q, fetch_d, tail_q, tail_d;
   logic [vaddr_width_p-1:0]    pc_mem_q    [ftq_els_p];
   logic                        taken_mem_q [ftq_els_p];

   logic [ftq_ptr_width_lp-1:0] head_idx, fetch_idx, tail_idx;
   logic                        full, fetch_v, alloc, ovr_en;
   ptr_t                        ovr_base, ovr_ptr, ovr_age, fetch_age;

   assign head_idx  = head_q[ftq_ptr_width_lp-1:0];
   assign fetch_idx = fetch_q[ftq_ptr_width_lp-1:0];
   assign tail_idx  = tail_q[ftq_ptr_width_lp-1:0];

   assign full    = (head_idx == tail_idx) && (head_q[wrap_lp] != tail_q[wrap_lp]);
   assign fetch_v = (fetch_q != tail_q);
   assign ovr_en  = ovr_v_i && !redirect_v_i;
   assign alloc   = (state_q == e_run) && !full && !redirect_v_i && !ovr_v_i;

   // An in-flight override index sits on head's lap unless it is below head's index.
   assign ovr_base  = {head_q[wrap_lp] ^ (ovr_idx_i < head_idx), ovr_idx_i};
   assign ovr_ptr   = ovr_base + ptr_t'(1);
   assign ovr_age   = ovr_base - head_q;
   assign fetch_age = fetch_q - head_q;

   always_comb begin
      state_d  = state_q;
      gen_pc_d = gen_pc_q;
      head_d   = head_q + ptr_t'(commit_v_i);
      fetch_d  = fetch_q;
      tail_d   = tail_q;
      if ((state_q == e_init) && init_done_i)
         state_d = e_run;
      if (redirect_v_i) begin
         fetch_d  = head_d;
         tail_d   = head_d;
         gen_pc_d = redirect_pc_i;
      end else if (ovr_v_i) begin
         fetch_d  = ovr_ptr;
         tail_d   = ovr_ptr;
         gen_pc_d = ovr_pc_i;
      end else begin
         fetch_d = fetch_q + ptr_t'(fetch_if.fetch_yumi_i);
         if (alloc) begin
            tail_d   = tail_q + ptr_t'(1);
            gen_pc_d = pred_taken_i ? pred_tgt_i
                                    : (gen_pc_q & ~blk_mask_lp) + blk_bytes_lp;
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q  <= e_init;
         gen_pc_q <= boot_pc_p;
         head_q   <= '0;
         fetch_q  <= '0;
         tail_q   <= '0;
      end else begin
         state_q  <= state_d;
         gen_pc_q <= gen_pc_d;
         head_q   <= head_d;
         fetch_q  <= fetch_d;
         tail_q   <= tail_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (alloc) begin
         pc_mem_q[tail_idx]    <= gen_pc_q;
         taken_mem_q[tail_idx] <= pred_taken_i;
      end else if (ovr_en) begin
         taken_mem_q[ovr_idx_i] <= 1'b1;
      end
   end

   assign gen_pc_o               = gen_pc_q;
   assign fetch_if.fetch_v_o     = fetch_v;
   assign fetch_if.fetch_pc_o    = fetch_v ? pc_mem_q[fetch_idx] : '0;
   assign fetch_if.fetch_taken_o = fetch_v ? taken_mem_q[fetch_idx] : 1'b0;
   assign fetch_if.fetch_idx_o   = fetch_idx;
   assign count_o                = tail_q - head_q;
   assign full_o                 = full;
   assign empty_o                = (head_q == tail_q);

   a_commit_fetched: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      commit_v_i |-> (head_q != fetch_q));
   a_ovr_in_flight: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      ovr_en |-> (ovr_age < fetch_age));

endmodule

// File: tb/tb_bp_fe_pc_gen_ftq.sv
// Bench for bp_fe_pc_gen_ftq: directed scenarios plus randomized traffic against a
// sequence-number queue model.
module tb_bp_fe_pc_gen_ftq;

   localparam int unsigned VA = 39;
   localparam int unsigned FB = 8;
   localparam int unsigned N  = 8;
   localparam int unsigned PW = 3;
   localparam logic [VA-1:0] BOOT   = 39'h0080000000;
   localparam logic [VA-1:0] BOOT_B = 39'h0080000006;

   logic          clk, reset_n, init_done, pred_taken, redirect_v, ovr_v, commit_v;
   logic [VA-1:0] pred_tgt, redirect_pc, ovr_pc, gen_pc;
   logic [PW-1:0] ovr_idx;
   logic [PW:0]   count;
   logic          full, empty;
   logic          init_b, pred_taken_b, full_b, empty_b;
   logic [VA-1:0] pred_tgt_b, gen_pc_b;
   logic [PW:0]   count_b;

   int unsigned n_checks, n_pass;

   // Reference model: absolute sequence numbers, slot = seq % N.
   logic [VA-1:0] m_gen;
   int unsigned   m_head, m_fetch, m_tail;
   bit            m_run;
   logic [VA-1:0] m_pc [N];
   bit            m_tk [N];

   bp_fe_pc_gen_ftq_if #(.vaddr_width_p(VA), .ftq_els_p(N)) fa ();
   bp_fe_pc_gen_ftq_if #(.vaddr_width_p(VA), .ftq_els_p(N)) fb ();

   bp_fe_pc_gen_ftq #(.vaddr_width_p(VA), .fetch_bytes_p(FB), .ftq_els_p(N), .boot_pc_p(BOOT)) dut (
      .clk_i(clk), .reset_n_i(reset_n), .init_done_i(init_done), .gen_pc_o(gen_pc),
      .pred_taken_i(pred_taken), .pred_tgt_i(pred_tgt),
      .redirect_v_i(redirect_v), .redirect_pc_i(redirect_pc),
      .ovr_v_i(ovr_v), .ovr_idx_i(ovr_idx), .ovr_pc_i(ovr_pc),
      .fetch_if(fa), .commit_v_i(commit_v),
      .count_o(count), .full_o(full), .empty_o(empty));

   bp_fe_pc_gen_ftq #(.vaddr_width_p(VA), .fetch_bytes_p(FB), .ftq_els_p(N), .boot_pc_p(BOOT_B)) dut_b (
      .clk_i(clk), .reset_n_i(reset_n), .init_done_i(init_b), .gen_pc_o(gen_pc_b),
      .pred_taken_i(pred_taken_b), .pred_tgt_i(pred_tgt_b),
      .redirect_v_i(1'b0), .redirect_pc_i('0),
      .ovr_v_i(1'b0), .ovr_idx_i('0), .ovr_pc_i('0),
      .fetch_if(fb), .commit_v_i(1'b0),
      .count_o(count_b), .full_o(full_b), .empty_o(empty_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [VA-1:0] next_seq(input logic [VA-1:0] g);
      longint unsigned t;
      t = (longint'(g) / FB) * FB + FB;
      return t[VA-1:0];
   endfunction

   task automatic model_reset();
      m_gen = BOOT; m_head = 0; m_fetch = 0; m_tail = 0; m_run = 0;
   endtask

   task automatic model_step();
      int unsigned nh, s;
      bit          alloc;
      if (!reset_n) begin model_reset(); return; end
      alloc = m_run && ((m_tail - m_head) != N) && !redirect_v && !ovr_v;
      nh    = m_head + commit_v;
      if (redirect_v) begin
         m_fetch = nh; m_tail = nh; m_gen = redirect_pc;
      end else if (ovr_v) begin
         s = m_head + ((int'(ovr_idx) + N - (m_head % N)) % N);
         m_tk[ovr_idx] = 1'b1;
         m_fetch = s + 1; m_tail = s + 1; m_gen = ovr_pc;
      end else begin
         m_fetch = m_fetch + fa.fetch_yumi_i;
         if (alloc) begin
            m_pc[m_tail % N] = m_gen;
            m_tk[m_tail % N] = pred_taken;
            m_tail++;
            m_gen = pred_taken ? pred_tgt : next_seq(m_gen);
         end
      end
      m_head = nh;
      if (init_done) m_run = 1'b1;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      init_done = 0; pred_taken = 0; pred_tgt = '0; redirect_v = 0; redirect_pc = '0;
      ovr_v = 0; ovr_idx = '0; ovr_pc = '0; commit_v = 0; fa.fetch_yumi_i = 0;
      init_b = 0; pred_taken_b = 0; pred_tgt_b = '0; fb.fetch_yumi_i = 0;
   endtask

   task automatic do_reset();
      idle();
      @(posedge clk); #1;
      reset_n = 0; model_reset();
      @(posedge clk); #1;
      reset_n = 1;
   endtask

   task automatic test_reset();
      idle();
      #2 reset_n = 0; model_reset();
      #1;
      n_checks++; if (fa.fetch_v_o !== 1'b0) $display("FAIL rst_fetch_v: got %b want 0", fa.fetch_v_o); else n_pass++;
      n_checks++; if (count !== 4'd0) $display("FAIL rst_count: got %0d want 0", count); else n_pass++;
      n_checks++; if (empty !== 1'b1 || full !== 1'b0) $display("FAIL rst_empty_full: got %b%b want 10", empty, full); else n_pass++;
      n_checks++; if (gen_pc !== BOOT) $display("FAIL rst_gen_pc: got %h want %h", gen_pc, BOOT); else n_pass++;
      n_checks++; if ({fa.fetch_pc_o, fa.fetch_taken_o, fa.fetch_idx_o} !== '0) $display("FAIL rst_fetch_fields: got %h/%b/%0d want 0", fa.fetch_pc_o, fa.fetch_taken_o, fa.fetch_idx_o); else n_pass++;
      @(posedge clk); #1;
      reset_n = 1;
   endtask

   task automatic test_boot_seq();
      tick(); tick();
      init_done = 1;
      tick();
      n_checks++; if (fa.fetch_v_o !== 1'b0 || gen_pc !== BOOT) $display("FAIL boot_pre_alloc: got v=%b pc=%h want v=0 pc=%h", fa.fetch_v_o, gen_pc, BOOT); else n_pass++;
      tick();
      n_checks++; if (fa.fetch_v_o !== 1'b1 || fa.fetch_pc_o !== 39'h0080000000 || fa.fetch_idx_o !== 3'd0) $display("FAIL boot_e0: got v=%b pc=%h idx=%0d want 1/80000000/0", fa.fetch_v_o, fa.fetch_pc_o, fa.fetch_idx_o); else n_pass++;
      fa.fetch_yumi_i = 1;
      tick();
      n_checks++; if (fa.fetch_pc_o !== 39'h0080000008 || fa.fetch_idx_o !== 3'd1) $display("FAIL boot_e1: got pc=%h idx=%0d want 80000008/1", fa.fetch_pc_o, fa.fetch_idx_o); else n_pass++;
      tick();
      n_checks++; if (fa.fetch_pc_o !== 39'h0080000010 || fa.fetch_idx_o !== 3'd2 || fa.fetch_taken_o !== 1'b0) $display("FAIL boot_e2: got pc=%h idx=%0d tk=%b want 80000010/2/0", fa.fetch_pc_o, fa.fetch_idx_o, fa.fetch_taken_o); else n_pass++;
      fa.fetch_yumi_i = 0;
   endtask

   task automatic test_unaligned();
      do_reset();
      init_b = 1;
      tick();
      tick();
      n_checks++; if (fb.fetch_pc_o !== BOOT_B || gen_pc_b !== 39'h0080000008) $display("FAIL unal_e0: got pc=%h gen=%h want %h/80000008", fb.fetch_pc_o, gen_pc_b, BOOT_B); else n_pass++;
      fb.fetch_yumi_i = 1; pred_taken_b = 1; pred_tgt_b = 39'h0080001000;
      tick();
      n_checks++; if (fb.fetch_pc_o !== 39'h0080000008 || fb.fetch_taken_o !== 1'b1 || gen_pc_b !== 39'h0080001000) $display("FAIL unal_taken: got pc=%h tk=%b gen=%h want 80000008/1/80001000", fb.fetch_pc_o, fb.fetch_taken_o, gen_pc_b); else n_pass++;
      pred_taken_b = 0;
      tick();
      n_checks++; if (fb.fetch_pc_o !== 39'h0080001000 || fb.fetch_taken_o !== 1'b0 || gen_pc_b !== 39'h0080001008) $display("FAIL unal_tgt: got pc=%h tk=%b gen=%h want 80001000/0/80001008", fb.fetch_pc_o, fb.fetch_taken_o, gen_pc_b); else n_pass++;
      fb.fetch_yumi_i = 0; init_b = 0;
   endtask

   task automatic test_full();
      do_reset();
      init_done = 1;
      tick();
      for (int i = 0; i < 8; i++) tick();
      n_checks++; if (full !== 1'b1 || count !== 4'd8 || gen_pc !== 39'h0080000040) $display("FAIL full_reach: got f=%b c=%0d gen=%h want 1/8/80000040", full, count, gen_pc); else n_pass++;
      pred_taken = 1; pred_tgt = 39'h0012345678;
      tick(); tick();
      n_checks++; if (count !== 4'd8 || gen_pc !== 39'h0080000040) $display("FAIL full_hold: got c=%0d gen=%h want 8/80000040", count, gen_pc); else n_pass++;
      pred_taken = 0;
      fa.fetch_yumi_i = 1;
      tick();
      fa.fetch_yumi_i = 0; commit_v = 1;
      tick();
      commit_v = 0;
      n_checks++; if (count !== 4'd7 || full !== 1'b0) $display("FAIL full_release: got c=%0d f=%b want 7/0", count, full); else n_pass++;
      tick();
      n_checks++; if (count !== 4'd8 || full !== 1'b1 || gen_pc !== 39'h0080000048) $display("FAIL full_resume: got c=%0d f=%b gen=%h want 8/1/80000048", count, full, gen_pc); else n_pass++;
      fa.fetch_yumi_i = 1;
      for (int i = 0; i < 7; i++) tick();
      fa.fetch_yumi_i = 0;
      n_checks++; if (fa.fetch_idx_o !== 3'd0 || fa.fetch_pc_o !== 39'h0080000040) $display("FAIL full_wrap: got idx=%0d pc=%h want 0/80000040", fa.fetch_idx_o, fa.fetch_pc_o); else n_pass++;
   endtask

   task automatic test_override();
      do_reset();
      init_done = 1;
      tick();
      tick();
      fa.fetch_yumi_i = 1;
      tick(); tick(); tick();
      fa.fetch_yumi_i = 0;
      tick();
      ovr_v = 1; ovr_idx = 3'd1; ovr_pc = 39'h0080002000;
      tick();
      ovr_v = 0;
      n_checks++; if (count !== 4'd2 || fa.fetch_v_o !== 1'b0 || gen_pc !== 39'h0080002000) $display("FAIL ovr_flush: got c=%0d v=%b gen=%h want 2/0/80002000", count, fa.fetch_v_o, gen_pc); else n_pass++;
      tick();
      n_checks++; if (fa.fetch_v_o !== 1'b1 || fa.fetch_idx_o !== 3'd2 || fa.fetch_pc_o !== 39'h0080002000 || count !== 4'd3) $display("FAIL ovr_next: got v=%b idx=%0d pc=%h c=%0d want 1/2/80002000/3", fa.fetch_v_o, fa.fetch_idx_o, fa.fetch_pc_o, count); else n_pass++;
   endtask

   task automatic test_redirect();
      do_reset();
      init_done = 1;
      tick();
      tick();
      fa.fetch_yumi_i = 1;
      tick();
      redirect_v = 1; redirect_pc = 39'h0080004000;
      ovr_v = 1; ovr_idx = 3'd0; ovr_pc = 39'h0080009000; commit_v = 1;
      tick();
      redirect_v = 0; ovr_v = 0; commit_v = 0; fa.fetch_yumi_i = 0;
      n_checks++; if (count !== 4'd0 || empty !== 1'b1 || fa.fetch_v_o !== 1'b0 || gen_pc !== 39'h0080004000) $display("FAIL redir_flush: got c=%0d e=%b v=%b gen=%h want 0/1/0/80004000", count, empty, fa.fetch_v_o, gen_pc); else n_pass++;
      tick();
      n_checks++; if (fa.fetch_v_o !== 1'b1 || fa.fetch_idx_o !== 3'd1 || fa.fetch_pc_o !== 39'h0080004000 || fa.fetch_taken_o !== 1'b0) $display("FAIL redir_next: got v=%b idx=%0d pc=%h tk=%b want 1/1/80004000/0", fa.fetch_v_o, fa.fetch_idx_o, fa.fetch_pc_o, fa.fetch_taken_o); else n_pass++;
   endtask

   task automatic test_reset_midstream();
      do_reset();
      init_done = 1;
      tick();
      for (int i = 0; i < 4; i++) tick();
      n_checks++; if (count !== 4'd4) $display("FAIL mid_pre: got c=%0d want 4", count); else n_pass++;
      init_done = 0;
      #2 reset_n = 0; model_reset();
      #1;
      n_checks++; if (count !== 4'd0 || fa.fetch_v_o !== 1'b0 || empty !== 1'b1 || full !== 1'b0 || gen_pc !== BOOT) $display("FAIL mid_async: got c=%0d v=%b e=%b f=%b gen=%h want 0/0/1/0/%h", count, fa.fetch_v_o, empty, full, gen_pc, BOOT); else n_pass++;
      @(posedge clk); #1;
      reset_n = 1;
      tick(); tick(); tick();
      n_checks++; if (count !== 4'd0 || fa.fetch_v_o !== 1'b0 || gen_pc !== BOOT) $display("FAIL mid_no_alloc: got c=%0d v=%b gen=%h want 0/0/%h", count, fa.fetch_v_o, gen_pc, BOOT); else n_pass++;
      init_done = 1;
      tick();
      n_checks++; if (count !== 4'd0) $display("FAIL mid_init_edge: got c=%0d want 0", count); else n_pass++;
      tick();
      n_checks++; if (count !== 4'd1 || fa.fetch_pc_o !== BOOT) $display("FAIL mid_resume: got c=%0d pc=%h want 1/%h", count, fa.fetch_pc_o, BOOT); else n_pass++;
   endtask

   task automatic test_random();
      logic [63:0]        r;
      logic [PW+PW+VA+3:0] got, exp;
      int unsigned        occ;
      do_reset();
      init_done = 1;
      tick();
      for (int c = 0; c < 3000; c++) begin
         pred_taken = ($urandom_range(3) == 0);
         r = {$urandom, $urandom}; pred_tgt = r[VA-1:0];
         r = {$urandom, $urandom}; redirect_pc = r[VA-1:0];
         r = {$urandom, $urandom}; ovr_pc = r[VA-1:0];
         fa.fetch_yumi_i = (m_fetch != m_tail) && ($urandom_range(1) == 1);
         commit_v   = (m_head != m_fetch) && ($urandom_range(2) != 0);
         redirect_v = ($urandom_range(63) == 0);
         ovr_v      = !redirect_v && (m_fetch != m_head) && ($urandom_range(15) == 0);
         ovr_idx    = PW'((m_head + $urandom_range(m_fetch - m_head - 1)) % N);
         tick();
         occ = m_tail - m_head;
         exp = {m_fetch != m_tail, PW'(m_fetch % N), (PW+1)'(occ), occ == N, occ == 0, m_gen};
         got = {fa.fetch_v_o, fa.fetch_idx_o, count, full, empty, gen_pc};
         n_checks++; if (got !== exp) $display("FAIL rand_state cyc %0d: got %h want %h", c, got, exp); else n_pass++;
         if (m_fetch != m_tail) begin
            n_checks++;
            if (fa.fetch_pc_o !== m_pc[m_fetch % N] || fa.fetch_taken_o !== m_tk[m_fetch % N])
               $display("FAIL rand_entry cyc %0d: got pc=%h tk=%b want pc=%h tk=%b", c, fa.fetch_pc_o, fa.fetch_taken_o, m_pc[m_fetch % N], m_tk[m_fetch % N]);
            else n_pass++;
         end
      end
      idle();
   endtask

   initial begin
      n_checks = 0; n_pass = 0;
      reset_n = 1'b1;
      idle();
      model_reset();
      test_reset();
      test_boot_seq();
      test_unaligned();
      test_full();
      test_override();
      test_redirect();
      test_reset_midstream();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
